// File: rtl/vx_avs_req_arb.sv
// Two-way DRAM request arbiter: merges host-copy (s0) and core (s1) request streams into one
// registered stage, tagging each with its source index, and steers responses back by that bit.
module vx_avs_req_arb #(
  parameter int unsigned DATAW    = 512,
  parameter int unsigned ADDRW    = 26,
  parameter int unsigned TAGW     = 8,
  parameter int unsigned BYTEENW  = DATAW / 8,
  parameter int unsigned OUT_TAGW = TAGW + 1
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req_valid_s0,
  input  logic                req_rw_s0,
  input  logic [BYTEENW-1:0]  req_byteen_s0,
  input  logic [ADDRW-1:0]    req_addr_s0,
  input  logic [DATAW-1:0]    req_data_s0,
  input  logic [TAGW-1:0]     req_tag_s0,
  output logic                req_ready_s0,

  input  logic                req_valid_s1,
  input  logic                req_rw_s1,
  input  logic [BYTEENW-1:0]  req_byteen_s1,
  input  logic [ADDRW-1:0]    req_addr_s1,
  input  logic [DATAW-1:0]    req_data_s1,
  input  logic [TAGW-1:0]     req_tag_s1,
  output logic                req_ready_s1,

  output logic                dram_req_valid,
  output logic                dram_req_rw,
  output logic [BYTEENW-1:0]  dram_req_byteen,
  output logic [ADDRW-1:0]    dram_req_addr,
  output logic [DATAW-1:0]    dram_req_data,
  output logic [OUT_TAGW-1:0] dram_req_tag,
  input  logic                dram_req_ready,

  input  logic                dram_rsp_valid,
  input  logic [DATAW-1:0]    dram_rsp_data,
  input  logic [OUT_TAGW-1:0] dram_rsp_tag,
  output logic                dram_rsp_ready,

  output logic                rsp_valid_s0,
  output logic [DATAW-1:0]    rsp_data_s0,
  output logic [TAGW-1:0]     rsp_tag_s0,
  input  logic                rsp_ready_s0,

  output logic                rsp_valid_s1,
  output logic [DATAW-1:0]    rsp_data_s1,
  output logic [TAGW-1:0]     rsp_tag_s1,
  input  logic                rsp_ready_s1
);

  logic                stage_ready;
  logic                grant;
  logic                grant_valid;
  logic                rsp_sel;

  logic                valid_q, valid_d;
  logic                prio_q, prio_d;
  logic                rw_q, rw_d;
  logic [BYTEENW-1:0]  byteen_q, byteen_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [DATAW-1:0]    data_q, data_d;
  logic [OUT_TAGW-1:0] tag_q, tag_d;

  always_comb begin
    stage_ready  = !valid_q || dram_req_ready;
    // prio only matters on contention; otherwise the lone valid source wins
    grant        = (req_valid_s0 && req_valid_s1) ? prio_q : req_valid_s1;
    grant_valid  = !reset && stage_ready && (req_valid_s0 || req_valid_s1);
    req_ready_s0 = grant_valid && !grant;
    req_ready_s1 = grant_valid && grant;

    valid_d  = valid_q;
    prio_d   = prio_q;
    rw_d     = rw_q;
    byteen_d = byteen_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tag_d    = tag_q;

    if (grant_valid) begin
      valid_d  = 1'b1;
      prio_d   = ~grant;
      rw_d     = grant ? req_rw_s1     : req_rw_s0;
      byteen_d = grant ? req_byteen_s1 : req_byteen_s0;
      addr_d   = grant ? req_addr_s1   : req_addr_s0;
      data_d   = grant ? req_data_s1   : req_data_s0;
      tag_d    = grant ? {1'b1, req_tag_s1} : {1'b0, req_tag_s0};
    end else if (dram_req_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      prio_q  <= prio_d;
    end
  end

  // Payload needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    rw_q     <= rw_d;
    byteen_q <= byteen_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
    tag_q    <= tag_d;
  end

  assign dram_req_valid  = valid_q;
  assign dram_req_rw     = rw_q;
  assign dram_req_byteen = byteen_q;
  assign dram_req_addr   = addr_q;
  assign dram_req_data   = data_q;
  assign dram_req_tag    = tag_q;

  // Responses return in order, so a stalled owner stalls the whole stream.
  always_comb begin
    rsp_sel        = dram_rsp_tag[OUT_TAGW-1];
    rsp_valid_s0   = dram_rsp_valid && !rsp_sel;
    rsp_valid_s1   = dram_rsp_valid && rsp_sel;
    rsp_data_s0    = dram_rsp_data;
    rsp_data_s1    = dram_rsp_data;
    rsp_tag_s0     = dram_rsp_tag[TAGW-1:0];
    rsp_tag_s1     = dram_rsp_tag[TAGW-1:0];
    dram_rsp_ready = rsp_sel ? rsp_ready_s1 : rsp_ready_s0;
  end

`ifndef SYNTHESIS
  int unsigned in_cnt, out_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= 0;
      out_cnt <= 0;
    end else begin
      if (grant_valid) in_cnt <= in_cnt + 1;
      if (dram_req_valid && dram_req_ready) out_cnt <= out_cnt + 1;
    end
  end

  a_one_ready: assert property (@(posedge clk) !(req_ready_s0 && req_ready_s1));

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (dram_req_valid && !dram_req_ready) |=>
      (dram_req_valid && $stable({dram_req_rw, dram_req_byteen, dram_req_addr,
                                  dram_req_data, dram_req_tag})));

  a_no_loss: assert property (@(posedge clk) disable iff (reset)
    (in_cnt - out_cnt) == 32'(dram_req_valid));
`endif

endmodule
